if_stage_ctrl: RTL and testbench
================================

Name: if_stage_ctrl

Overview:
- Instruction-fetch stage that consumes the stall/flush controls issued by the hazard detection unit: `pcwrite`, `ifid_write` and `ifid_flush`.
- Owns the PC register, the next-PC selection (sequential, branch, jump) and the IF/ID pipeline register.
- Sits between instruction memory and the ID stage.
- Adds a post-reset warm-up state and valid tracking, so bubbles are explicit rather than encoded as all-zero instructions.

Parameters:
- PC_W, 32, width of the program counter and all target addresses.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- pcwrite_i  input  1  from hazard unit; 1 = PC may advance.
- ifid_write_i  input  1  from hazard unit; 1 = IF/ID register may load.
- ifid_flush_i  input  1  from hazard unit; 1 = IF/ID loads a bubble.
- branch_i  input  1  taken branch resolved in MEM.
- branch_target_i  input  PC_W  target of the taken branch.
- jump_i  input  1  jump decoded in ID.
- jump_target_i  input  PC_W  target of the jump.
- imem_instr_i  input  INSTR_W  combinational instruction-memory read data for `pc_o`.
- pc_o  output  PC_W  current fetch address, driven to instruction memory.
- ifid_pc_o  output  PC_W  PC+4 of the instruction held in IF/ID.
- ifid_instr_o  output  INSTR_W  instruction held in IF/ID.
- ifid_valid_o  output  1  1 = IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - `pc_o` = RESET_PC.
  - `ifid_pc_o` = 0, `ifid_instr_o` = 0, `ifid_valid_o` = 0.
  - FSM enters WARMUP.
- FSM states:
  - WARMUP: exactly one cycle after reset deassertion. PC advances to RESET_PC+4 and IF/ID loads the instruction at RESET_PC with valid = 1. Hazard inputs are ignored in this state. Always moves to RUN.
  - RUN: steady state; the FSM stays here until reset.
- Next-PC in RUN, highest priority first:
  1. `branch_i` = 1: PC <= `branch_target_i`.
  2. `jump_i` = 1: PC <= `jump_target_i`.
  3. `pcwrite_i` = 1: PC <= PC+4.
  4. Otherwise PC holds.
- A redirect (branch or jump) overrides `pcwrite_i` = 0.
- PC+4 arithmetic is modulo 2^PC_W; 0xFFFF_FFFC wraps to 0. No alignment check.
- IF/ID register in RUN:
  - If `ifid_flush_i` = 1, or a redirect is present: load a bubble (instr = 0, pc = 0, valid = 0). Flush takes precedence over `ifid_write_i` = 0.
  - Else if `ifid_write_i` = 1: load `imem_instr_i`, PC+4, valid = 1.
  - Else: hold all three fields.
- Load-use stall pattern (pcwrite = 0, ifid_write = 0, flush = 0): PC and IF/ID both hold; no instruction is lost or duplicated.
- Latency: an instruction at address A appears on `ifid_instr_o` one cycle after `pc_o` = A with no stall.
- Outputs are registered only; there is no combinational path from any input to any output.
- Reset asserted mid-stall or mid-redirect: all state is discarded immediately and the block re-enters WARMUP on release.

Optional Feature:
- Macro: `IF_STAGE_PERF_EN`.
- When defined, adds outputs `stall_cnt_o` [31:0] and `flush_cnt_o` [31:0], both reset to 0 and saturating at 0xFFFF_FFFF.
  - `stall_cnt_o` increments on each RUN cycle with `pcwrite_i` = 0 and no redirect.
  - `flush_cnt_o` increments on each RUN cycle where IF/ID loads a bubble.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package `pipe_pkg`:
  - FSM state enum (WARMUP, RUN).
  - `NOP_INSTR` = 0.
  - `PC_INCR` = 4.
  - The `ifid_t` struct {pc, instr, valid}.
- One natural sub-module: `pc_reg`, which holds the PC register plus the next-PC priority mux. The IF/ID register stays in the top level.

Test Plan:
- Reset, then 4 free-running cycles with imem returning 0x11, 0x22, 0x33, 0x44 -> `pc_o` 0→4→8→C→10; `ifid_instr_o` 0x11, 0x22, 0x33, 0x44 with valid = 1 from the cycle after WARMUP.
- At PC = 0x8, hold pcwrite = 0 and ifid_write = 0 for 2 cycles -> `pc_o` stays 0x8, IF/ID holds 0x22 with valid = 1, then the sequence resumes with 0x33 and no duplication.
- `branch_i` = 1 with target 0x100, while pcwrite = 0 and ifid_write = 0 -> next `pc_o` = 0x100 and IF/ID becomes a bubble (valid = 0, instr = 0).
- `jump_i` = 1 (target 0x40) and `branch_i` = 1 (target 0x200) in the same cycle -> `pc_o` = 0x200, IF/ID becomes a bubble.
- PC forced to 0xFFFF_FFFC by branch, then one free cycle -> `pc_o` = 0x0000_0000.
- Assert rst_i low mid-stall at PC = 0x20 -> `pc_o` = 0 immediately, valid = 0; WARMUP is re-entered on release. With `IF_STAGE_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e : fetch FSM states (WARMUP, RUN)
//   - NOP_INSTR     : encoding loaded into IF/ID for a bubble
//   - PC_INCR       : sequential fetch stride in bytes
//   - ifid_t        : IF/ID register contents at the default 32-bit widths
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned PIPE_PC_W    = 32;
    localparam int unsigned PIPE_INSTR_W = 32;

    localparam logic [PIPE_INSTR_W-1:0] NOP_INSTR = '0;
    localparam int unsigned             PC_INCR   = 4;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PIPE_PC_W-1:0]    pc;
        logic [PIPE_INSTR_W-1:0] instr;
        logic                    valid;
    } ifid_t;

endpackage

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter register with the next-PC priority mux.
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-low reset (PC <= RESET_PC)
//   warmup_i         fetch FSM is in WARMUP: unconditionally advance by 4
//   run_i            fetch FSM is in RUN: apply redirect / pcwrite rules
//   branch_i         taken branch (highest priority)
//   branch_target_i  branch target
//   jump_i           jump (second priority)
//   jump_target_i    jump target
//   pcwrite_i        hazard unit permits a sequential advance
//   pc_o             current fetch address
//   pc_plus4_o       pc_o + 4, wrapping modulo 2^PC_W
// ---------------------------------------------------------------------------
module pc_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            warmup_i,
    input  logic            run_i,
    input  logic            branch_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            pcwrite_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // The add simply drops the carry, so 0xFFFF_FFFC + 4 wraps to 0.
    assign pc_plus4_o = pc_q + PC_W'(PC_INCR);
    assign pc_o       = pc_q;

    // Next-PC selection. A redirect wins even when the hazard unit is
    // stalling the PC, since the stalled instruction is being squashed.
    always_comb begin
        pc_d = pc_q;
        if (warmup_i) begin
            pc_d = pc_plus4_o;
        end else if (run_i) begin
            if (branch_i) begin
                pc_d = branch_target_i;
            end else if (jump_i) begin
                pc_d = jump_target_i;
            end else if (pcwrite_i) begin
                pc_d = pc_plus4_o;
            end
        end
    end

    // PC state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_stage_ctrl.sv
// ---------------------------------------------------------------------------
// if_stage_ctrl
// Instruction-fetch stage: PC (via pc_reg), next-PC selection and the
// IF/ID pipeline register, driven by the hazard unit's stall/flush controls.
// A one-cycle WARMUP state after reset fetches the instruction at RESET_PC
// regardless of the hazard inputs; RUN is the steady state.
// Bubbles are marked with ifid_valid_o = 0 (and zeroed pc/instr fields).
//
// Ports:
//   clk_i, rst_i         clock / asynchronous active-low reset
//   pcwrite_i            1 = PC may advance sequentially
//   ifid_write_i         1 = IF/ID may load
//   ifid_flush_i         1 = IF/ID loads a bubble
//   branch_i, branch_target_i   taken branch from MEM
//   jump_i, jump_target_i       jump from ID
//   imem_instr_i         instruction memory read data for pc_o
//   pc_o                 fetch address
//   ifid_pc_o            PC+4 of the instruction held in IF/ID
//   ifid_instr_o         instruction held in IF/ID
//   ifid_valid_o         1 = real instruction, 0 = bubble
//
// Optional feature (macro IF_STAGE_PERF_EN):
//   stall_cnt_o          saturating count of RUN cycles with a stalled PC
//   flush_cnt_o          saturating count of RUN cycles loading a bubble
// ---------------------------------------------------------------------------
module if_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pcwrite_i,
    input  logic               ifid_write_i,
    input  logic               ifid_flush_i,
    input  logic               branch_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic               jump_i,
    input  logic [PC_W-1:0]    jump_target_i,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o
`endif
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } ifid_reg_t;

    localparam ifid_reg_t IFID_BUBBLE = '{pc: '0, instr: INSTR_W'(NOP_INSTR), valid: 1'b0};

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic            in_warmup;
    logic            in_run;
    logic            redirect;
    logic            load_bubble;
    logic            load_instr;
    logic [PC_W-1:0] pc_plus4;
    ifid_reg_t       ifid_q;

    assign redirect = branch_i | jump_i;

    // Fetch FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state and decoded control. WARMUP lasts exactly one
    // cycle and ignores the hazard unit, whose outputs may not yet be
    // meaningful straight out of reset.
    always_comb begin
        state_d     = state_q;
        in_warmup   = 1'b0;
        in_run      = 1'b0;
        load_bubble = 1'b0;
        load_instr  = 1'b0;
        unique case (state_q)
            WARMUP: begin
                in_warmup  = 1'b1;
                load_instr = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                in_run      = 1'b1;
                load_bubble = ifid_flush_i | redirect;
                load_instr  = ~(ifid_flush_i | redirect) & ifid_write_i;
                state_d     = RUN;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .warmup_i        (in_warmup),
        .run_i           (in_run),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .pcwrite_i       (pcwrite_i),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4)
    );

    // IF/ID pipeline register. A bubble (flush or redirect) beats a stall,
    // so a squashed instruction never lingers in ID while IF/ID is frozen.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_q <= IFID_BUBBLE;
        end else if (load_bubble) begin
            ifid_q <= IFID_BUBBLE;
        end else if (load_instr) begin
            ifid_q <= '{pc: pc_plus4, instr: imem_instr_i, valid: 1'b1};
        end
    end

    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_instr_o = ifid_q.instr;
    assign ifid_valid_o = ifid_q.valid;

`ifdef IF_STAGE_PERF_EN
    logic stall_event;

    // A redirect is not counted as a stall even with pcwrite low, because
    // the PC still moves.
    assign stall_event = in_run & ~pcwrite_i & ~redirect;

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_event && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (load_bubble && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_stage_ctrl
// Self-checking bench for if_stage_ctrl: a table of directed vectors, a
// hand-written mid-stall reset sequence and a randomized run checked against
// a behavioural model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_if_stage_ctrl;
    import pipe_pkg::*;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcwrite;
    logic        ifid_write;
    logic        ifid_flush;
    logic        branch;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int passed = 0;
    int total  = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    ifid_t       m_ifid;
    bit          m_first;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    if_stage_ctrl #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .pcwrite_i       (pcwrite),
        .ifid_write_i    (ifid_write),
        .ifid_flush_i    (ifid_flush),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .imem_instr_i    (imem_instr),
        .pc_o            (pc),
        .ifid_pc_o       (ifid_pc),
        .ifid_instr_o    (ifid_instr),
        .ifid_valid_o    (ifid_valid)
`ifdef IF_STAGE_PERF_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // Instruction memory contents: address A holds ((A/4)+1)*0x11.
    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    always_comb imem_instr = imem_fn(pc);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc    = RST_PC;
        m_ifid  = '{pc: 32'h0, instr: 32'h0, valid: 1'b0};
        m_first = 1'b1;
        m_stall = 32'h0;
        m_flush = 32'h0;
    endtask

    // One clock of the fetch stage as described behaviourally: the first
    // cycle after reset fetches RESET_PC unconditionally, later cycles obey
    // redirect > pcwrite for the PC and flush/redirect > write for IF/ID.
    task automatic modelStep(input bit pw, input bit iw, input bit fl,
                             input bit br, input logic [31:0] bt,
                             input bit jp, input logic [31:0] jt);
        logic [31:0] seq;
        bit          squash;
        seq = m_pc + 32'd4;
        if (m_first) begin
            m_ifid  = '{pc: seq, instr: imem_fn(m_pc), valid: 1'b1};
            m_pc    = seq;
            m_first = 1'b0;
        end else begin
            squash = fl || br || jp;
            if (squash) m_ifid = '{pc: 32'h0, instr: 32'h0, valid: 1'b0};
            else if (iw) m_ifid = '{pc: seq, instr: imem_fn(m_pc), valid: 1'b1};
            if (!pw && !br && !jp && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (squash && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
            if (br) m_pc = bt;
            else if (jp) m_pc = jt;
            else if (pw) m_pc = seq;
        end
    endtask

    // Called just after a falling edge: drives inputs, advances the model,
    // and returns #1 after the next rising edge, ready for checking.
    task automatic applyStimulus(input bit pw, input bit iw, input bit fl,
                                 input bit br, input logic [31:0] bt,
                                 input bit jp, input logic [31:0] jt);
        pcwrite       = pw;
        ifid_write    = iw;
        ifid_flush    = fl;
        branch        = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        modelStep(pw, iw, fl, br, bt, jp, jt);
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".pc"}, pc, m_pc);
        checkOutput({tag, ".ifid_pc"}, ifid_pc, m_ifid.pc);
        checkOutput({tag, ".ifid_instr"}, ifid_instr, m_ifid.instr);
        checkOutput({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_ifid.valid});
`ifdef IF_STAGE_PERF_EN
        checkOutput({tag, ".stall_cnt"}, stall_cnt, m_stall);
        checkOutput({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
    endtask

    typedef struct {
        string       name;
        bit          pw, iw, fl, br;
        logic [31:0] bt;
        bit          jp;
        logic [31:0] jt;
        logic [31:0] e_pc, e_ipc, e_instr;
        bit          e_valid;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // name, pw, iw, fl, br, bt, jp, jt, pc, ifid_pc, ifid_instr, valid
        vecs[0]  = '{"warmup",      0, 0, 1, 0, 32'h0,         0, 32'h0,  32'h4,         32'h4,   32'h11, 1};
        vecs[1]  = '{"free1",       1, 1, 0, 0, 32'h0,         0, 32'h0,  32'h8,         32'h8,   32'h22, 1};
        vecs[2]  = '{"stall1",      0, 0, 0, 0, 32'h0,         0, 32'h0,  32'h8,         32'h8,   32'h22, 1};
        vecs[3]  = '{"stall2",      0, 0, 0, 0, 32'h0,         0, 32'h0,  32'h8,         32'h8,   32'h22, 1};
        vecs[4]  = '{"resume1",     1, 1, 0, 0, 32'h0,         0, 32'h0,  32'hC,         32'hC,   32'h33, 1};
        vecs[5]  = '{"resume2",     1, 1, 0, 0, 32'h0,         0, 32'h0,  32'h10,        32'h10,  32'h44, 1};
        vecs[6]  = '{"branch_stl",  0, 0, 0, 1, 32'h100,       0, 32'h0,  32'h100,       32'h0,   32'h0,  0};
        vecs[7]  = '{"after_br",    1, 1, 0, 0, 32'h0,         0, 32'h0,  32'h104,       32'h104, imem_fn(32'h100), 1};
        vecs[8]  = '{"br_over_jp",  1, 1, 0, 1, 32'h200,       1, 32'h40, 32'h200,       32'h0,   32'h0,  0};
        vecs[9]  = '{"jump_stl",    0, 0, 0, 0, 32'h0,         1, 32'h40, 32'h40,        32'h0,   32'h0,  0};
        vecs[10] = '{"flush_nowr",  1, 0, 1, 0, 32'h0,         0, 32'h0,  32'h44,        32'h0,   32'h0,  0};
        vecs[11] = '{"write_nopc",  0, 1, 0, 0, 32'h0,         0, 32'h0,  32'h44,        32'h48,  imem_fn(32'h44), 1};
        vecs[12] = '{"br_top",      1, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,  32'hFFFF_FFFC, 32'h0,   32'h0,  0};
        vecs[13] = '{"wrap",        1, 1, 0, 0, 32'h0,         0, 32'h0,  32'h0,         32'h0,   imem_fn(32'hFFFF_FFFC), 1};

        rst_n = 1'b0;
        pcwrite = 0; ifid_write = 0; ifid_flush = 0;
        branch = 0; branch_target = '0; jump = 0; jump_target = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.pc", pc, RST_PC);
        checkOutput("reset.ifid_pc", ifid_pc, 32'h0);
        checkOutput("reset.ifid_instr", ifid_instr, 32'h0);
        checkOutput("reset.ifid_valid", {31'h0, ifid_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pw, vecs[i].iw, vecs[i].fl, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].jt);
            checkOutput({vecs[i].name, ".pc"}, pc, vecs[i].e_pc);
            checkOutput({vecs[i].name, ".ifid_pc"}, ifid_pc, vecs[i].e_ipc);
            checkOutput({vecs[i].name, ".ifid_instr"}, ifid_instr, vecs[i].e_instr);
            checkOutput({vecs[i].name, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, vecs[i].e_valid});
            @(negedge clk);
        end

        // Run freely to PC = 0x20, stall there, then reset mid-stall.
        for (int guard = 0; guard < 16 && m_pc != 32'h20; guard++) begin
            applyStimulus(1, 1, 0, 0, 32'h0, 0, 32'h0);
            checkModel("to_0x20");
            @(negedge clk);
        end
        checkOutput("reached_0x20", pc, 32'h20);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        checkModel("stall_0x20");
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midstall_rst.pc", pc, 32'h0);
        checkOutput("midstall_rst.valid", {31'h0, ifid_valid}, 32'h0);
        checkModel("midstall_rst");
        @(posedge clk);
        #1;
        checkModel("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        // Hazard inputs still say "stall" but WARMUP must ignore them.
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("rewarm.pc", pc, 32'h4);
        checkOutput("rewarm.instr", ifid_instr, 32'h11);
        checkModel("rewarm");
        @(negedge clk);

        // Randomized run against the model, with occasional async resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                modelReset();
                #1;
                checkModel("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                applyStimulus($urandom_range(0, 3) != 0,
                              $urandom_range(0, 3) != 0,
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 9) == 0,
                              $urandom(),
                              $urandom_range(0, 9) == 0,
                              $urandom());
                checkModel("rnd");
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
